// File: rtl/mux8_way16.sv
// Eight-way, 16-bit mux built as a three-level 2:1 tree.
// Define MUX8WAY16_REG_OUT_EN to register the output (1-cycle latency, sync reset to 0).
module mux8_way16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] d7,
  input  logic [15:0] d6,
  input  logic [15:0] d5,
  input  logic [15:0] d4,
  input  logic [15:0] d3,
  input  logic [15:0] d2,
  input  logic [15:0] d1,
  input  logic [15:0] d0,
  input  logic [2:0]  sel,
  output logic [15:0] out
);

  logic [15:0] lvl1 [4];
  logic [15:0] lvl2 [2];
  logic [15:0] muxed;

  // sel[0] picks within each adjacent pair, sel[1] between pairs, sel[2] between halves
  assign lvl1[0] = sel[0] ? d1 : d0;
  assign lvl1[1] = sel[0] ? d3 : d2;
  assign lvl1[2] = sel[0] ? d5 : d4;
  assign lvl1[3] = sel[0] ? d7 : d6;

  assign lvl2[0] = sel[1] ? lvl1[1] : lvl1[0];
  assign lvl2[1] = sel[1] ? lvl1[3] : lvl1[2];

  assign muxed = sel[2] ? lvl2[1] : lvl2[0];

`ifdef MUX8WAY16_REG_OUT_EN
  always_ff @(posedge clk) begin
    if (reset)
      out <= 16'h0000;
    else
      out <= muxed;
  end
`else
  // clk and reset are kept on the port list so both builds share one footprint
  logic unused;
  assign unused = &{1'b0, clk, reset};
  assign out = muxed;
`endif

endmodule

// File: tb/tb_mux8_way16.sv
// Self-checking bench for mux8_way16; covers both builds via MUX8WAY16_REG_OUT_EN.
module tb_mux8_way16;

  logic        clk;
  logic        reset;
  logic [15:0] d7, d6, d5, d4, d3, d2, d1, d0;
  logic [2:0]  sel;
  logic [15:0] out;

  int testsRun;
  int failCount;

  typedef struct {
    logic [2:0]        sel;
    logic [7:0][15:0]  d;
    logic [15:0]       expected;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  localparam logic [7:0][15:0] COMMON = {16'h89AB, 16'h789A, 16'h6789, 16'h5678,
                                         16'h4567, 16'h3456, 16'h2345, 16'h1234};
  localparam logic [7:0][15:0] WALK5  = {16'h0000, 16'h0000, 16'hFFFF, 16'h0000,
                                         16'h0000, 16'h0000, 16'h0000, 16'h0000};

  mux8_way16 dut (
    .clk  (clk),
    .reset(reset),
    .d7   (d7),
    .d6   (d6),
    .d5   (d5),
    .d4   (d4),
    .d3   (d3),
    .d2   (d2),
    .d1   (d1),
    .d0   (d0),
    .sel  (sel),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(logic [2:0] s, logic [7:0][15:0] d, logic [15:0] e);
    vec_t v;
    v.sel      = s;
    v.d        = d;
    v.expected = e;
    return v;
  endfunction

  task automatic applyStimulus(input logic [2:0] s, input logic [7:0][15:0] d);
    sel = s;
    d0 = d[0]; d1 = d[1]; d2 = d[2]; d3 = d[3];
    d4 = d[4]; d5 = d[5]; d6 = d[6]; d7 = d[7];
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] expected);
    testsRun++;
    if (out !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: out=%h expected=%h", tag, out, expected);
    end
  endtask

  // Let the applied stimulus reach the output: one edge in the registered build
  task automatic settle();
`ifdef MUX8WAY16_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #2;
`endif
  endtask

  initial begin
    testsRun  = 0;
    failCount = 0;
    reset     = 1'b1;
    applyStimulus(3'd0, COMMON);

    vecs[0]  = mkVec(3'd0, COMMON, 16'h1234);
    vecs[1]  = mkVec(3'd1, COMMON, 16'h2345);
    vecs[2]  = mkVec(3'd2, COMMON, 16'h3456);
    vecs[3]  = mkVec(3'd3, COMMON, 16'h4567);
    vecs[4]  = mkVec(3'd4, COMMON, 16'h5678);
    vecs[5]  = mkVec(3'd5, COMMON, 16'h6789);
    vecs[6]  = mkVec(3'd6, COMMON, 16'h789A);
    vecs[7]  = mkVec(3'd7, COMMON, 16'h89AB);
    vecs[8]  = mkVec(3'd5, WALK5,  16'hFFFF);
    vecs[9]  = mkVec(3'd4, WALK5,  16'h0000);
    vecs[10] = mkVec(3'd3, COMMON, 16'h4567);

`ifdef MUX8WAY16_REG_OUT_EN
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset_state", 16'h0000);
`endif
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].sel, vecs[i].d);
      settle();
      checkOutput($sformatf("vec%0d_sel%0d", i, vecs[i].sel), vecs[i].expected);
    end

    // Only sel[2] flips (3 -> 7), following on from the last table entry
    @(negedge clk);
    applyStimulus(3'd7, COMMON);
    settle();
    checkOutput("sel_bit2_3to7", 16'h89AB);

`ifdef MUX8WAY16_REG_OUT_EN
    // Reset overrides sel/data, then normal capture resumes on the next edge
    @(negedge clk);
    applyStimulus(3'd7, COMMON);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_midstream", 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_release", 16'h89AB);

    // Mid-cycle sel change must not reach out until the following edge
    @(negedge clk);
    applyStimulus(3'd1, COMMON);
    @(posedge clk);
    #1;
    checkOutput("capture_sel1", 16'h2345);
    @(negedge clk);
    applyStimulus(3'd6, COMMON);
    #1;
    checkOutput("capture_hold", 16'h2345);
    @(posedge clk);
    #1;
    checkOutput("capture_sel6", 16'h789A);
`else
    // Reset and clock have no influence on the combinational output
    @(negedge clk);
    applyStimulus(3'd2, COMMON);
    #1;
    checkOutput("comb_sel2", 16'h3456);
    reset = 1'b1;
    #1;
    checkOutput("comb_reset_high", 16'h3456);
    @(posedge clk);
    #1;
    checkOutput("comb_reset_edge", 16'h3456);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("comb_reset_low", 16'h3456);
    @(posedge clk);
    #1;
    checkOutput("comb_after_edge", 16'h3456);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
